axi_lite_reg_bridge: RTL and testbench

AXI4-Lite slave that converts single-beat AXI4-Lite reads and writes into a simple register strobe/acknowledge interface. It sits between the system interconnect and a peripheral's register file, e.g. the audio controller's control/status/version registers. It handles one transaction at a time, presents the address and data to user logic, and returns OKAY or SLVERR based on the user's invalid-address flag.

---
 rtl/axi_lite_pkg.sv | 24 ++
 rtl/axi_lite_reg_bridge_if.sv | 54 +++++
 rtl/axi_lite_reg_bridge.sv | 164 ++++++++++++++++
 tb/tb_axi_lite_reg_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register bridge: response codes,
// bridge FSM state type and a response-selection helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WR_STROBE = 3'd1,
      ST_WR_WAIT   = 3'd2,
      ST_WR_RESP   = 3'd3,
      ST_RD_STROBE = 3'd4,
      ST_RD_WAIT   = 3'd5,
      ST_RD_RESP   = 3'd6
   } bridge_state_e;

   // Response code for a completed register access.
   function automatic logic [1:0] resp_of(input logic invalid_addr);
      return invalid_addr ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_lite_reg_bridge_if.sv
// Bundle of AXI4-Lite slave channels plus the register strobe/ack side.
// Signal prefixes are from the bridge's point of view (i_ = into bridge).
// slave modport = bridge; master modport = interconnect + register file.
interface axi_lite_reg_bridge_if #(
   parameter int ADDR_WIDTH = 16
);
   // AXI write address / data / response
   logic                  i_awvalid;
   logic                  o_awready;
   logic [ADDR_WIDTH-1:0] i_awaddr;
   logic                  i_wvalid;
   logic                  o_wready;
   logic [31:0]           i_wdata;
   logic [3:0]            i_wstrb;
   logic                  o_bvalid;
   logic                  i_bready;
   logic [1:0]            o_bresp;
   // AXI read address / data
   logic                  i_arvalid;
   logic                  o_arready;
   logic [ADDR_WIDTH-1:0] i_araddr;
   logic                  o_rvalid;
   logic                  i_rready;
   logic [1:0]            o_rresp;
   logic [31:0]           o_rdata;
   // Register-file side
   logic [ADDR_WIDTH-1:0] o_reg_address;
   logic                  i_reg_invalid_addr;
   logic                  o_reg_in_rdy;
   logic                  i_reg_in_ack;
   logic [31:0]           o_reg_in_data;
   logic                  o_reg_out_req;
   logic                  i_reg_out_rdy;
   logic [31:0]           i_reg_out_data;

   modport slave (
      input  i_awvalid, i_awaddr, i_wvalid, i_wdata, i_wstrb, i_bready,
             i_arvalid, i_araddr, i_rready,
             i_reg_invalid_addr, i_reg_in_ack, i_reg_out_rdy, i_reg_out_data,
      output o_awready, o_wready, o_bvalid, o_bresp,
             o_arready, o_rvalid, o_rresp, o_rdata,
             o_reg_address, o_reg_in_rdy, o_reg_in_data, o_reg_out_req
   );

   modport master (
      output i_awvalid, i_awaddr, i_wvalid, i_wdata, i_wstrb, i_bready,
             i_arvalid, i_araddr, i_rready,
             i_reg_invalid_addr, i_reg_in_ack, i_reg_out_rdy, i_reg_out_data,
      input  o_awready, o_wready, o_bvalid, o_bresp,
             o_arready, o_rvalid, o_rresp, o_rdata,
             o_reg_address, o_reg_in_rdy, o_reg_in_data, o_reg_out_req
   );

endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave -> register strobe/ack bridge, one transaction at a time.
// Latency: handshake at 0, strobe at 1, response valid the cycle after ack/rdy.
// Backpressure: readies only in IDLE; B/R held until bready/rready.
// Ports: clk, rst (async active-low), bus (axi_lite_reg_bridge_if.slave).
// Optional: AXI_LITE_REG_BRIDGE_TIMEOUT_EN adds a SLVERR timeout after
// TIMEOUT_CYCLES wait cycles without ack/rdy (reads then return 0).
module axi_lite_reg_bridge
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   axi_lite_reg_bridge_if.slave bus
);

   bridge_state_e         r_state;
   logic [ADDR_WIDTH-1:0] r_reg_address;
   logic [31:0]           r_reg_in_data;
   logic [31:0]           r_rdata;
   logic [1:0]            r_bresp;
   logic [1:0]            r_rresp;
   logic                  r_bvalid;
   logic                  r_rvalid;
   logic                  r_reg_in_rdy;
   logic                  r_reg_out_req;

   logic                  w_idle;
   logic                  w_wr_hs;
   logic                  w_rd_hs;
   logic                  w_timeout;
   logic [3:0]            w_unused_wstrb;

   // Strobes are ignored: every write is a full-word write.
   assign w_unused_wstrb = bus.i_wstrb;

   // Write beats read when both arrive together.
   assign w_idle  = (r_state == ST_IDLE);
   assign w_wr_hs = w_idle & bus.i_awvalid & bus.i_wvalid;
   assign w_rd_hs = w_idle & bus.i_arvalid & ~(bus.i_awvalid & bus.i_wvalid);

`ifdef AXI_LITE_REG_BRIDGE_TIMEOUT_EN
   localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_wait_cnt;
   logic             w_in_wait;

   assign w_in_wait = (r_state == ST_WR_WAIT) || (r_state == ST_RD_WAIT);
   // Fires on the last permitted wait cycle; an ack in that same cycle wins.
   assign w_timeout = w_in_wait && (r_wait_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wait_cnt <= '0;
      end else if (w_in_wait) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
         r_wait_cnt <= '0;
      end
   end
`else
   logic [31:0] w_unused_timeout;

   assign w_timeout        = 1'b0;
   assign w_unused_timeout = TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_reg_address <= '0;
         r_reg_in_data <= '0;
         r_rdata       <= '0;
         r_bresp       <= RESP_OKAY;
         r_rresp       <= RESP_OKAY;
         r_bvalid      <= 1'b0;
         r_rvalid      <= 1'b0;
         r_reg_in_rdy  <= 1'b0;
         r_reg_out_req <= 1'b0;
      end else begin
         // Strobes are single-cycle pulses.
         r_reg_in_rdy  <= 1'b0;
         r_reg_out_req <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_wr_hs) begin
                  r_reg_address <= bus.i_awaddr;
                  r_reg_in_data <= bus.i_wdata;
                  r_reg_in_rdy  <= 1'b1;
                  r_state       <= ST_WR_STROBE;
               end else if (w_rd_hs) begin
                  r_reg_address <= bus.i_araddr;
                  r_reg_out_req <= 1'b1;
                  r_state       <= ST_RD_STROBE;
               end
            end

            // An ack coincident with the strobe is accepted straight away.
            ST_WR_STROBE, ST_WR_WAIT: begin
               if (bus.i_reg_in_ack) begin
                  r_bresp  <= resp_of(bus.i_reg_invalid_addr);
                  r_bvalid <= 1'b1;
                  r_state  <= ST_WR_RESP;
               end else if (w_timeout) begin
                  r_bresp  <= RESP_SLVERR;
                  r_bvalid <= 1'b1;
                  r_state  <= ST_WR_RESP;
               end else begin
                  r_state  <= ST_WR_WAIT;
               end
            end

            ST_WR_RESP: begin
               if (bus.i_bready) begin
                  r_bvalid <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end

            ST_RD_STROBE, ST_RD_WAIT: begin
               if (bus.i_reg_out_rdy) begin
                  r_rdata  <= bus.i_reg_out_data;
                  r_rresp  <= resp_of(bus.i_reg_invalid_addr);
                  r_rvalid <= 1'b1;
                  r_state  <= ST_RD_RESP;
               end else if (w_timeout) begin
                  r_rdata  <= '0;
                  r_rresp  <= RESP_SLVERR;
                  r_rvalid <= 1'b1;
                  r_state  <= ST_RD_RESP;
               end else begin
                  r_state  <= ST_RD_WAIT;
               end
            end

            ST_RD_RESP: begin
               if (bus.i_rready) begin
                  r_rvalid <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_awready     = w_wr_hs;
   assign bus.o_wready      = w_wr_hs;
   assign bus.o_arready     = w_rd_hs;
   assign bus.o_bvalid      = r_bvalid;
   assign bus.o_bresp       = r_bresp;
   assign bus.o_rvalid      = r_rvalid;
   assign bus.o_rresp       = r_rresp;
   assign bus.o_rdata       = r_rdata;
   assign bus.o_reg_address = r_reg_address;
   assign bus.o_reg_in_rdy  = r_reg_in_rdy;
   assign bus.o_reg_in_data = r_reg_in_data;
   assign bus.o_reg_out_req = r_reg_out_req;

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Testbench for axi_lite_reg_bridge: acts as AXI master and as the register
// file behind the bridge; a word-addressed reference memory predicts read data.
// Directed cases first, then randomized reads/writes with random latencies.
module tb_axi_lite_reg_bridge;

   logic clk = 1'b0;
   logic rst = 1'b0;

   axi_lite_reg_bridge_if #(.ADDR_WIDTH(16)) bus ();

   axi_lite_reg_bridge #(
      .ADDR_WIDTH     (16),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference memory (what software expects) and the register file contents
   // actually written through the bridge.
   logic [31:0] model [64];
   logic [31:0] uregs [64];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after posedge; outputs sampled at negedge.
   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   function automatic logic [15:0] mk_addr(input int idx);
      logic [5:0] i6;
      i6 = idx[5:0];
      return {8'h00, i6, 2'b00};
   endfunction

   // Starts in an IDLE cycle just after the edge; ends positioned in the
   // first free cycle after the B handshake.
   task automatic do_write(input int idx, input logic [31:0] data, input int k,
                           input bit inv, input int hold, input bit with_ar);
      logic [15:0] addr;
      addr = mk_addr(idx);
      bus.i_awvalid = 1'b1;
      bus.i_wvalid  = 1'b1;
      bus.i_awaddr  = addr;
      bus.i_wdata   = data;
      bus.i_wstrb   = 4'($urandom);
      if (with_ar) begin
         bus.i_arvalid = 1'b1;
         bus.i_araddr  = addr ^ 16'h0004;
      end
      smp;
      chk("awready", bus.o_awready, 1);
      chk("wready", bus.o_wready, 1);
      chk("arready_vs_write", bus.o_arready, 0);
      for (int c = 1; c <= k; c++) begin
         nxt;
         bus.i_awvalid          = 1'b0;
         bus.i_wvalid           = 1'b0;
         bus.i_reg_in_ack       = (c == k);
         bus.i_reg_invalid_addr = (c == k) ? inv : 1'($urandom);
         smp;
         if (c == 1) begin
            chk("in_rdy_strobe", bus.o_reg_in_rdy, 1);
            chk("in_data", bus.o_reg_in_data, data);
            chk("wr_address", 32'(bus.o_reg_address), 32'(addr));
         end else begin
            chk("in_rdy_single", bus.o_reg_in_rdy, 0);
         end
         chk("bvalid_early", bus.o_bvalid, 0);
         if (with_ar) chk("arready_busy", bus.o_arready, 0);
         if (c == k && !inv) begin
            uregs[idx] = bus.o_reg_in_data;
            model[idx] = data;
         end
      end
      for (int h = 0; h <= hold; h++) begin
         nxt;
         bus.i_bready           = (h == hold);
         bus.i_reg_in_ack       = 1'($urandom);
         bus.i_reg_invalid_addr = 1'($urandom);
         smp;
         chk("bvalid", bus.o_bvalid, 1);
         chk("bresp", 32'(bus.o_bresp), inv ? 32'd2 : 32'd0);
         chk("in_rdy_resp", bus.o_reg_in_rdy, 0);
         if (with_ar) chk("arready_resp", bus.o_arready, 0);
      end
      nxt;
      bus.i_bready           = 1'b0;
      bus.i_reg_in_ack       = 1'b0;
      bus.i_reg_invalid_addr = 1'b0;
   endtask

   task automatic do_read(input int idx, input int k, input bit inv, input int hold);
      logic [15:0] addr;
      logic [31:0] supplied;
      logic [31:0] exp;
      addr     = mk_addr(idx);
      supplied = inv ? $urandom : uregs[idx];
      exp      = inv ? supplied : model[idx];
      bus.i_arvalid = 1'b1;
      bus.i_araddr  = addr;
      smp;
      chk("arready", bus.o_arready, 1);
      chk("awready_vs_read", bus.o_awready, 0);
      for (int c = 1; c <= k; c++) begin
         nxt;
         bus.i_arvalid          = 1'b0;
         bus.i_reg_out_rdy      = (c == k);
         bus.i_reg_invalid_addr = (c == k) ? inv : 1'($urandom);
         bus.i_reg_out_data     = (c == k) ? supplied : $urandom;
         smp;
         if (c == 1) begin
            chk("out_req_strobe", bus.o_reg_out_req, 1);
            chk("rd_address", 32'(bus.o_reg_address), 32'(addr));
         end else begin
            chk("out_req_single", bus.o_reg_out_req, 0);
         end
         chk("rvalid_early", bus.o_rvalid, 0);
      end
      for (int h = 0; h <= hold; h++) begin
         nxt;
         bus.i_rready           = (h == hold);
         bus.i_reg_out_rdy      = 1'($urandom);
         bus.i_reg_out_data     = $urandom;
         bus.i_reg_invalid_addr = 1'($urandom);
         smp;
         chk("rvalid", bus.o_rvalid, 1);
         chk("rresp", 32'(bus.o_rresp), inv ? 32'd2 : 32'd0);
         chk("rdata", bus.o_rdata, exp);
      end
      nxt;
      bus.i_rready           = 1'b0;
      bus.i_reg_out_rdy      = 1'b0;
      bus.i_reg_invalid_addr = 1'b0;
      smp;
      chk("rvalid_drop", bus.o_rvalid, 0);
      chk("rdata_hold", bus.o_rdata, exp);
      nxt;
   endtask

   initial begin
      bus.i_awvalid = 0; bus.i_awaddr = '0; bus.i_wvalid = 0; bus.i_wdata = '0;
      bus.i_wstrb = '0; bus.i_bready = 0; bus.i_arvalid = 0; bus.i_araddr = '0;
      bus.i_rready = 0; bus.i_reg_invalid_addr = 0; bus.i_reg_in_ack = 0;
      bus.i_reg_out_rdy = 0; bus.i_reg_out_data = '0;
      for (int i = 0; i < 64; i++) begin
         model[i] = '0;
         uregs[i] = '0;
      end

      // Reset state
      repeat (3) nxt;
      smp;
      chk("rst_bvalid", bus.o_bvalid, 0);
      chk("rst_rvalid", bus.o_rvalid, 0);
      chk("rst_in_rdy", bus.o_reg_in_rdy, 0);
      chk("rst_out_req", bus.o_reg_out_req, 0);
      chk("rst_rdata", bus.o_rdata, 0);
      nxt;
      rst = 1'b1;

      // Directed: basic write, basic read, invalid-address write/read
      do_write(0, 32'h0000_000F, 1, 0, 0, 0);
      do_write(7, 32'h1000_0000, 1, 0, 0, 0);
      do_read(7, 1, 0, 0);
      do_write(16, 32'hDEAD_BEEF, 2, 1, 0, 0);
      do_read(16, 1, 1, 0);
      // Simultaneous AW/W/AR with bready held low 5 cycles; read follows
      do_write(3, 32'hA5A5_0001, 1, 0, 5, 1);
      do_read(3, 2, 0, 1);

      // Reset in the middle of WR_WAIT
      bus.i_awvalid = 1'b1; bus.i_wvalid = 1'b1;
      bus.i_awaddr = mk_addr(9); bus.i_wdata = 32'h1234_5678;
      nxt;
      bus.i_awvalid = 1'b0; bus.i_wvalid = 1'b0;
      nxt;
      rst = 1'b0;
      #1;
      chk("midrst_bvalid", bus.o_bvalid, 0);
      chk("midrst_in_data", bus.o_reg_in_data, 0);
      chk("midrst_address", 32'(bus.o_reg_address), 0);
      chk("midrst_rdata", bus.o_rdata, 0);
      chk("midrst_rresp", 32'(bus.o_rresp), 0);
      nxt;
      rst = 1'b1;
      bus.i_reg_in_ack = 1'b1;
      smp;
      nxt;
      bus.i_reg_in_ack = 1'b0;
      smp;
      chk("stray_ack_bvalid", bus.o_bvalid, 0);
      nxt;
      do_read(7, 1, 0, 0);

`ifdef AXI_LITE_REG_BRIDGE_TIMEOUT_EN
      // Read never acknowledged: SLVERR with zero data after 8 wait cycles
      bus.i_arvalid = 1'b1;
      bus.i_araddr  = mk_addr(7);
      smp;
      chk("tmo_arready", bus.o_arready, 1);
      for (int c = 1; c <= 9; c++) begin
         nxt;
         bus.i_arvalid = 1'b0;
         smp;
         chk("tmo_rvalid_early", bus.o_rvalid, 0);
      end
      nxt;
      smp;
      chk("tmo_rvalid", bus.o_rvalid, 1);
      chk("tmo_rresp", 32'(bus.o_rresp), 2);
      chk("tmo_rdata", bus.o_rdata, 0);
      nxt;
      bus.i_rready = 1'b1;
      nxt;
      bus.i_rready = 1'b0;
`endif

      // Randomized traffic
      for (int t = 0; t < 60; t++) begin
         int  idx;
         int  k;
         int  hold;
         bit  inv;
         idx  = $urandom_range(0, 63);
         k    = $urandom_range(1, 4);
         hold = $urandom_range(0, 3);
         inv  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 1) == 0) begin
            bit with_ar;
            with_ar = ($urandom_range(0, 3) == 0);
            do_write(idx, $urandom, k, inv, hold, with_ar);
            if (with_ar) do_read($urandom_range(0, 63), $urandom_range(1, 4), 0, $urandom_range(0, 2));
         end else begin
            do_read(idx, k, inv, hold);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
